// File: rtl/xilly_pack_pkg.sv
// Shared types and helpers for the 8-to-32 Xillybus width packer.
// Word geometry, FSM state type and partial-word padding.
package xilly_pack_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 2;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Lanes at or above cnt take the pad byte; lanes below keep accumulated data.
    function automatic logic [8*BYTES_PER_WORD-1:0] pad_word(
        input logic [8*BYTES_PER_WORD-1:0] acc,
        input logic [CNT_W-1:0]            cnt,
        input logic [7:0]                  pad
    );
        logic [8*BYTES_PER_WORD-1:0] w;
        w = acc;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i >= int'(cnt)) begin
                w[i*8 +: 8] = pad;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/xilly_pack_pend_reg.sv
// Single-entry holding register between packer and FIFO write port.
// Load and drain in the same cycle keeps the entry full; clr wipes it.
module xilly_pack_pend_reg #(
    parameter int DW = 32,
    parameter int NW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load_vld,
    input  logic [DW-1:0] load_dat,
    input  logic [NW-1:0] load_nbytes,
    input  logic          drain,
    output logic          pend_vld,
    output logic [DW-1:0] pend_dat,
    output logic [NW-1:0] pend_nbytes
);

    logic          vld_q, vld_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [NW-1:0] nb_q,  nb_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        nb_d  = nb_q;
        if (drain) begin
            vld_d = 1'b0;
        end
        if (load_vld) begin
            vld_d = 1'b1;
            dat_d = load_dat;
            nb_d  = load_nbytes;
        end
        if (clr) begin
            vld_d = 1'b0;
            dat_d = '0;
            nb_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            nb_q  <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            nb_q  <= nb_d;
        end
    end

    assign pend_vld    = vld_q;
    assign pend_dat    = dat_q;
    assign pend_nbytes = nb_q;

endmodule

// File: rtl/xilly_pack_8to32.sv
// Packs the 8-bit Xillybus stream into little-endian 32-bit FIFO words; word out one cycle after 4th byte.
// in_full follows FIFO full while a word is pending, and holds during a close flush. PACK_STATS_EN adds counters.
module xilly_pack_8to32
    import xilly_pack_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter bit         FLUSH_ON_CLOSE = 1'b1
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        quiesce,
    input  logic        in_wren,
    input  logic [7:0]  in_data,
    input  logic        in_open,
    output logic        in_full,
    output logic        out_wr_en,
    output logic [31:0] out_din,
    output logic [2:0]  out_nbytes,
    input  logic        out_full
`ifdef PACK_STATS_EN
    ,
    output logic [31:0] stat_words,
    output logic [15:0] stat_flushes
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        acc_q, acc_d;
    logic               open_q, open_d;

    logic               pend_vld;
    logic               drain;
    logic               accept;
    logic               close_evt;
    logic               load;
    logic [31:0]        load_dat;
    logic [2:0]         load_nb;

    assign drain     = pend_vld && !out_full;
    assign out_wr_en = drain;
    assign in_full   = (pend_vld && out_full) || (state_q == FLUSH);
    assign accept    = in_wren && !in_full;
    assign close_evt = open_q && !in_open;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        open_d   = in_open;
        load     = 1'b0;
        load_dat = acc_q;
        load_nb  = 3'd4;
        if (state_q == FLUSH) begin
            if (!pend_vld || drain) begin
                load     = 1'b1;
                load_dat = pad_word(acc_q, cnt_q, PAD_BYTE);
                load_nb  = {1'b0, cnt_q};
                cnt_d    = '0;
                acc_d    = '0;
                state_d  = FILL;
            end
        end else begin
            if (accept) begin
                if (cnt_q == 2'd3) begin
                    load     = 1'b1;
                    load_dat = {in_data, acc_q[23:0]};
                    load_nb  = 3'd4;
                    acc_d    = '0;
                end else begin
                    acc_d[{cnt_q, 3'b000} +: 8] = in_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            // A byte arriving with the close belongs to the word being closed.
            if (close_evt && (cnt_d != '0)) begin
                if (FLUSH_ON_CLOSE) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
        end
        if (quiesce) begin
            state_d = FILL;
            cnt_d   = '0;
            acc_d   = '0;
            open_d  = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            acc_q   <= '0;
            open_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            open_q  <= open_d;
        end
    end

    xilly_pack_pend_reg #(
        .DW(32),
        .NW(3)
    ) u_pend (
        .clk         (bus_clk),
        .rst_n       (bus_rst_n),
        .clr         (quiesce),
        .load_vld    (load),
        .load_dat    (load_dat),
        .load_nbytes (load_nb),
        .drain       (drain),
        .pend_vld    (pend_vld),
        .pend_dat    (out_din),
        .pend_nbytes (out_nbytes)
    );

`ifdef PACK_STATS_EN
    logic        flush_evt;
    logic [31:0] words_q, words_d;
    logic [15:0] flushes_q, flushes_d;

    assign flush_evt = (state_q == FLUSH) && (!pend_vld || drain);

    always_comb begin
        words_d   = words_q;
        flushes_d = flushes_q;
        if (drain && (words_q != '1)) begin
            words_d = words_q + 32'd1;
        end
        if (flush_evt && (flushes_q != '1)) begin
            flushes_d = flushes_q + 16'd1;
        end
        if (quiesce) begin
            words_d   = '0;
            flushes_d = '0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            words_q   <= '0;
            flushes_q <= '0;
        end else begin
            words_q   <= words_d;
            flushes_q <= flushes_d;
        end
    end

    assign stat_words   = words_q;
    assign stat_flushes = flushes_q;
`endif

endmodule
